// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: FIFO controller that owns the port of a single-port RAM.
// Each cycle, it issues either one write or one read to the RAM, never both.
// Write and read requests are arbitrated round-robin.
// Popped data is staged in a one-entry output register, so rd_data is always registered.
module sp_ram_fifo_ctrl #(
  parameter int DW    = 4,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready,
  output logic [AW+1:0] level,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_addr,
  output logic          ram_w,
  input  logic [DW-1:0] ram_dout
);

  localparam int LW = AW + 2;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_mem_cnt;
  logic          r_rd_pend;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_last_gnt;   // 0 = last grant was a write, 1 = a read

  logic w_need_rd;
  logic w_need_wr;
  logic w_gnt_wr;
  logic w_gnt_rd;
  logic w_pop;

  // A read is only requested when the staging register will be free to take its result
  assign w_need_rd = !r_rd_pend && (r_mem_cnt != '0) && (!r_rd_valid || rd_ready);
  assign w_need_wr = wr_valid && (r_mem_cnt != (AW+1)'(DEPTH));
  assign w_pop     = r_rd_valid && rd_ready;

  // Single-grant arbiter: a lone requester wins; on contention the side not served last wins.
  // Grants are held off while reset is asserted so the RAM port stays idle.
  always_comb begin
    w_gnt_wr = 1'b0;
    w_gnt_rd = 1'b0;
    if (rst_n) begin
      if (w_need_wr && w_need_rd) begin
        if (r_last_gnt) w_gnt_wr = 1'b1;
        else            w_gnt_rd = 1'b1;
      end else begin
        w_gnt_wr = w_need_wr;
        w_gnt_rd = w_need_rd;
      end
    end
  end

  // An idle cycle still presents rptr, so the RAM performs a harmless read
  assign wr_ready = w_gnt_wr;
  assign ram_w    = w_gnt_wr;
  assign ram_addr = w_gnt_wr ? r_wptr : r_rptr;
  assign ram_din  = wr_data;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign level    = LW'(r_mem_cnt) + LW'(r_rd_pend) + LW'(r_rd_valid);

  // Pointers and occupancy of the RAM; pointers wrap naturally because DEPTH is 2**AW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_cnt <= '0;
    end else if (w_gnt_wr) begin
      r_wptr    <= r_wptr + 1'b1;
      r_mem_cnt <= r_mem_cnt + 1'b1;
    end else if (w_gnt_rd) begin
      r_rptr    <= r_rptr + 1'b1;
      r_mem_cnt <= r_mem_cnt - 1'b1;
    end
  end

  // Round-robin history, updated only on cycles that carry a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_gnt <= 1'b0;
    else if (w_gnt_wr) r_last_gnt <= 1'b0;
    else if (w_gnt_rd) r_last_gnt <= 1'b1;
  end

  // In-flight read tracking and capture of RAM data into the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend <= w_gnt_rd;
      if (r_rd_pend) begin
        r_rd_data  <= ram_dout;
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed testbench for sp_ram_fifo_ctrl with a behavioural single-port RAM.
module tb_sp_ram_fifo_ctrl;

  localparam int DW = 4;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW+1:0] level;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_addr;
  logic          ram_w;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;
  int k;
  int n;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .level    (level),
    .ram_din  (ram_din),
    .ram_addr (ram_addr),
    .ram_w    (ram_w),
    .ram_dout (ram_dout)
  );

  // Single-port RAM: write when w=1, otherwise registered read with 1-cycle latency
  always @(posedge clk) begin
    if (ram_w) mem[ram_addr] <= ram_din;
    else       ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a push request present while in reset
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 4'h3; rd_ready = 1'b0;
    #3;
    chk("rst_wr_ready", 8'(wr_ready), 8'd0);
    chk("rst_ram_w",    8'(ram_w),    8'd0);
    chk("rst_level",    8'(level),    8'd0);
    chk("rst_rd_valid", 8'(rd_valid), 8'd0);
    chk("rst_rd_data",  8'(rd_data),  8'd0);
    wr_valid = 1'b0;
    #9 rst_n = 1'b1;
    tick();

    // Two pushes with no pop; the read of the first entry wins arbitration in between
    wr_valid = 1'b1; wr_data = 4'b1010; #1;
    chk("t2_w0_ready", 8'(wr_ready), 8'd1);
    chk("t2_w0_ram_w", 8'(ram_w),    8'd1);
    chk("t2_w0_addr",  8'(ram_addr), 8'd0);
    tick();
    wr_data = 4'b1001; #1;
    chk("t2_rdwin_ready", 8'(wr_ready), 8'd0);
    chk("t2_rdwin_ram_w", 8'(ram_w),    8'd0);
    chk("t2_rdwin_addr",  8'(ram_addr), 8'd0);
    tick();
    chk("t2_w1_ram_w", 8'(ram_w),    8'd1);
    chk("t2_w1_addr",  8'(ram_addr), 8'd1);
    chk("t2_w1_level", 8'(level),    8'd1);
    tick();
    wr_valid = 1'b0; #1;
    chk("t2_rd_valid", 8'(rd_valid), 8'd1);
    chk("t2_rd_data",  8'(rd_data),  8'b1010);
    chk("t2_level",    8'(level),    8'd2);
    chk("t2_idle_w",   8'(ram_w),    8'd0);

    // Pop both entries in order
    rd_ready = 1'b1;
    tick();
    chk("t3_bubble_valid", 8'(rd_valid), 8'd0);
    chk("t3_bubble_level", 8'(level),    8'd1);
    tick();
    chk("t3_second_valid", 8'(rd_valid), 8'd1);
    chk("t3_second_data",  8'(rd_data),  8'b1001);
    tick();
    chk("t3_empty_valid", 8'(rd_valid), 8'd0);
    chk("t3_empty_level", 8'(level),    8'd0);
    rd_ready = 1'b0;

    // Fill until full: 32 entries in RAM plus one staged
    k = 0; wr_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wr_data = 4'(k % 16); #1;
      if (wr_ready) k++;
      tick();
    end
    #1;
    chk("t4_accepted",  8'(k),        8'd33);
    chk("t4_level",     8'(level),    8'd33);
    chk("t4_full_rdy",  8'(wr_ready), 8'd0);
    chk("t4_full_w",    8'(ram_w),    8'd0);
    chk("t4_head",      8'(rd_data),  8'd0);
    wr_valid = 1'b0; rd_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 120 && n < 33; c++) begin
      if (rd_valid) begin
        chk("t4_order", 8'(rd_data), 8'(n % 16));
        n++;
      end
      tick();
    end
    chk("t4_popped",      8'(n),     8'd33);
    chk("t4_drain_level", 8'(level), 8'd0);

    // Continuous push and pop from empty: grants alternate write/read
    k = 0; n = 0; wr_valid = 1'b1; rd_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      wr_data = 4'((k * 5 + 3) % 16); #1;
      chk("t5_alternate", 8'(ram_w), 8'((c % 2) == 0));
      if (rd_valid) begin
        chk("t5_order", 8'(rd_data), 8'((n * 5 + 3) % 16));
        n++;
      end
      if (wr_ready) k++;
      tick();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 20 && n < 50; c++) begin
      if (rd_valid) begin
        chk("t5_order", 8'(rd_data), 8'((n * 5 + 3) % 16));
        n++;
      end
      tick();
    end
    chk("t5_pushes", 8'(k),     8'd50);
    chk("t5_pops",   8'(n),     8'd50);
    chk("t5_level",  8'(level), 8'd0);
    rd_ready = 1'b0;

    // Reset while a RAM read is in flight
    wr_valid = 1'b1; wr_data = 4'b0111;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("t6_pend_level", 8'(level), 8'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_valid", 8'(rd_valid), 8'd0);
    chk("t6_rst_level", 8'(level),    8'd0);
    chk("t6_rst_w",     8'(ram_w),    8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("t6_no_stale_valid", 8'(rd_valid), 8'd0);
    chk("t6_no_stale_level", 8'(level),    8'd0);
    tick();
    chk("t6_no_stale_valid2", 8'(rd_valid), 8'd0);
    wr_valid = 1'b1; wr_data = 4'b1100; #1;
    chk("t6_push_ready", 8'(wr_ready), 8'd1);
    chk("t6_push_addr",  8'(ram_addr), 8'd0);
    tick();
    wr_valid = 1'b0; #1;
    chk("t6_rd_grant_w", 8'(ram_w), 8'd0);
    tick();
    chk("t6_lat_valid", 8'(rd_valid), 8'd0);
    tick();
    chk("t6_valid", 8'(rd_valid), 8'd1);
    chk("t6_data",  8'(rd_data),  8'b1100);
    chk("t6_level", 8'(level),    8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
